// File: rtl/intr_sequencer.sv
// rtl/intr_sequencer.sv - interrupt accept/return sequencer for the 8-line interrupt manager
// Optional INTR_MASK_EN adds a per-line mask register (ports mask_we, mask_din).
module intr_sequencer #(
  parameter int               VEC_W      = 10,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(10'h3E0),
  parameter int               VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef INTR_MASK_EN
  input  logic             mask_we,
  input  logic [7:0]       mask_din,
`endif
  input  logic [7:0]       min_bit_s,
  input  logic [7:0]       min_bit_a,
  input  logic             int_enable,
  input  logic             cpu_ack,
  input  logic             cpu_reti,
  output logic             intr_req,
  output logic [VEC_W-1:0] vector,
  output logic [7:0]       call_intr,
  output logic [7:0]       s_return_intr,
  output logic [3:0]       depth,
  output logic             spur_reti
);

  typedef enum logic [2:0] {IDLE, REQ, CALL, SYNC, RET} state_t;

  state_t           state_q, state_d;
  logic [7:0]       sel_q, sel_d;
  logic [3:0]       depth_q, depth_d;
  logic             spur_q, spur_d;
  logic             intr_req_q, intr_req_d;
  logic [VEC_W-1:0] vector_q, vector_d;
  logic [7:0]       call_q, call_d;
  logic [7:0]       ret_q, ret_d;
  logic             mask_ok;
  logic             win;
  logic [2:0]       idx;

`ifdef INTR_MASK_EN
  logic [7:0]       mask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= 8'hFF;
    end else if (mask_we) begin
      mask_q <= mask_din;
    end
  end

  assign mask_ok = (min_bit_s & mask_q) != 8'h00;
`else
  assign mask_ok = 1'b1;
`endif

  assign win = (min_bit_s != 8'h00) && mask_ok &&
               ((min_bit_a == 8'h00) || (min_bit_s < min_bit_a));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    depth_d = depth_q;
    spur_d  = spur_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_reti) begin
          state_d = RET;
        end else if (int_enable && win) begin
          state_d = REQ;
          sel_d   = min_bit_s;
        end
      end
      REQ: begin
        if (win) sel_d = min_bit_s;
        // reti withdraws the request even if the CPU acked in the same cycle
        if (cpu_reti) begin
          state_d = RET;
        end else if (!int_enable || !win) begin
          state_d = IDLE;
        end else if (cpu_ack) begin
          state_d = CALL;
        end
      end
      CALL: begin
        if (depth_q != 4'd8) depth_d = depth_q + 4'd1;
        state_d = SYNC;
      end
      SYNC: state_d = IDLE;
      RET: begin
        if (depth_q != 4'd0) depth_d = depth_q - 4'd1;
        else                 spur_d  = 1'b1;
        state_d = SYNC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (sel_d[i]) idx = 3'(i);
    end
  end

  // Outputs are computed from the next state so they appear in the cycle the state is entered
  always_comb begin
    intr_req_d = (state_d == REQ);
    vector_d   = (state_d == REQ) ? VEC_BASE + VEC_W'(idx) * VEC_W'(VEC_STRIDE) : '0;
    call_d     = (state_d == CALL) ? sel_d : 8'h00;
    ret_d      = ((state_d == RET) && (depth_q != 4'd0)) ? min_bit_a : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_q      <= 8'h00;
      depth_q    <= 4'd0;
      spur_q     <= 1'b0;
      intr_req_q <= 1'b0;
      vector_q   <= '0;
      call_q     <= 8'h00;
      ret_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      depth_q    <= depth_d;
      spur_q     <= spur_d;
      intr_req_q <= intr_req_d;
      vector_q   <= vector_d;
      call_q     <= call_d;
      ret_q      <= ret_d;
    end
  end

  assign intr_req      = intr_req_q;
  assign vector        = vector_q;
  assign call_intr     = call_q;
  assign s_return_intr = ret_q;
  assign depth         = depth_q;
  assign spur_reti     = spur_q;

endmodule

// File: tb/tb_intr_sequencer.sv
// tb/tb_intr_sequencer.sv - directed self-checking bench for intr_sequencer
module tb_intr_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] min_bit_s = 8'h00;
  logic [7:0] min_bit_a = 8'h00;
  logic       int_enable = 1'b0;
  logic       cpu_ack = 1'b0;
  logic       cpu_reti = 1'b0;
  logic       intr_req;
  logic [9:0] vector;
  logic [7:0] call_intr;
  logic [7:0] s_return_intr;
  logic [3:0] depth;
  logic       spur_reti;
`ifdef INTR_MASK_EN
  logic       mask_we = 1'b0;
  logic [7:0] mask_din = 8'h00;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  intr_sequencer dut (
    .clk           (clk),
    .reset         (reset),
`ifdef INTR_MASK_EN
    .mask_we       (mask_we),
    .mask_din      (mask_din),
`endif
    .min_bit_s     (min_bit_s),
    .min_bit_a     (min_bit_a),
    .int_enable    (int_enable),
    .cpu_ack       (cpu_ack),
    .cpu_reti      (cpu_reti),
    .intr_req      (intr_req),
    .vector        (vector),
    .call_intr     (call_intr),
    .s_return_intr (s_return_intr),
    .depth         (depth),
    .spur_reti     (spur_reti)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held with random inputs
    min_bit_s  = 8'($urandom);
    min_bit_a  = 8'($urandom);
    int_enable = 1'($urandom_range(0, 1));
    cpu_ack    = 1'($urandom_range(0, 1));
    cpu_reti   = 1'($urandom_range(0, 1));
    cyc(); cyc();
    chk("rst_req", intr_req, 0);
    chk("rst_vec", vector, 0);
    chk("rst_call", call_intr, 0);
    chk("rst_ret", s_return_intr, 0);
    chk("rst_depth", depth, 0);
    chk("rst_spur", spur_reti, 0);
    reset = 1'b1; min_bit_s = 0; min_bit_a = 0; int_enable = 0; cpu_ack = 0; cpu_reti = 0;
    cyc(); cyc(); cyc();
    chk("idle_req", intr_req, 0);
    chk("idle_depth", depth, 0);

    // single interrupt on line 2
    min_bit_s = 8'h04; int_enable = 1;
    cyc();
    chk("s_req", intr_req, 1);
    chk("s_vec", vector, 10'h3E8);
    cpu_ack = 1;
    cyc();
    chk("s_call", call_intr, 8'h04);
    chk("s_call_req", intr_req, 0);
    cpu_ack = 0; min_bit_a = 8'h04;
    cyc();
    chk("s_call_done", call_intr, 0);
    chk("s_depth1", depth, 1);
    cyc(); cyc();
    chk("s_inservice_noreq", intr_req, 0);
    cpu_reti = 1;
    cyc();
    chk("s_ret", s_return_intr, 8'h04);
    chk("s_ret_nocall", call_intr, 0);
    cpu_reti = 0; min_bit_s = 0; min_bit_a = 0;
    cyc();
    chk("s_ret_done", s_return_intr, 0);
    chk("s_depth0", depth, 0);
    cyc();

    // nesting: line 3 in service, line 1 preempts
    min_bit_s = 8'h08;
    cyc();
    chk("n_vec3", vector, 10'h3EC);
    cpu_ack = 1;
    cyc();
    chk("n_call3", call_intr, 8'h08);
    cpu_ack = 0; min_bit_a = 8'h08;
    cyc();
    chk("n_depth1", depth, 1);
    min_bit_s = 8'h02;
    cyc(); cyc();
    chk("n_req1", intr_req, 1);
    chk("n_vec1", vector, 10'h3E4);
    cpu_ack = 1;
    cyc();
    chk("n_call1", call_intr, 8'h02);
    cpu_ack = 0; min_bit_a = 8'h02;
    cyc();
    chk("n_depth2", depth, 2);
    min_bit_s = 8'h08; min_bit_a = 8'h08;
    cyc(); cyc();
    chk("n_equal_noreq", intr_req, 0);
    cpu_reti = 1;
    cyc();
    chk("n_ret", s_return_intr, 8'h08);
    cpu_reti = 0;
    cyc();
    chk("n_depth_back1", depth, 1);
    cyc();
    cpu_reti = 1;
    cyc();
    cpu_reti = 0; min_bit_s = 0; min_bit_a = 0;
    cyc();
    chk("n_depth_back0", depth, 0);
    cyc();

    // higher line replaces pending request before ack
    min_bit_s = 8'h10;
    cyc();
    chk("r_vec4", vector, 10'h3F0);
    min_bit_s = 8'h01;
    cyc();
    chk("r_req", intr_req, 1);
    chk("r_vec0", vector, 10'h3E0);
    cpu_ack = 1;
    cyc();
    chk("r_call0", call_intr, 8'h01);
    cpu_ack = 0; min_bit_a = 8'h01;
    cyc();
    chk("r_depth1", depth, 1);
    cyc();
    cpu_reti = 1;
    cyc();
    chk("r_ret0", s_return_intr, 8'h01);
    cpu_reti = 0; min_bit_s = 0; min_bit_a = 0;
    cyc();
    chk("r_depth0", depth, 0);
    cyc();

    // ack and reti together in REQ, depth 0 makes it spurious
    min_bit_s = 8'h04;
    cyc();
    cpu_ack = 1; cpu_reti = 1;
    cyc();
    chk("x_nocall", call_intr, 0);
    chk("x_noret", s_return_intr, 0);
    chk("x_noreq", intr_req, 0);
    cpu_ack = 0; cpu_reti = 0; min_bit_s = 0;
    cyc();
    chk("x_spur", spur_reti, 1);
    chk("x_depth", depth, 0);
    cyc(); cyc();
    chk("x_spur_sticky", spur_reti, 1);

    // int_enable withdrawal, then reset during CALL
    min_bit_s = 8'h02; int_enable = 1;
    cyc();
    chk("e_req", intr_req, 1);
    int_enable = 0;
    cyc();
    chk("e_withdraw", intr_req, 0);
    int_enable = 1;
    cyc();
    cpu_ack = 1;
    cyc();
    chk("e_call", call_intr, 8'h02);
    reset = 0; cpu_ack = 0;
    #1;
    chk("e_rst_call", call_intr, 0);
    chk("e_rst_depth", depth, 0);
    chk("e_rst_spur", spur_reti, 0);
    #2;
    reset = 1; min_bit_s = 0;
    cyc();
    chk("e_after_call", call_intr, 0);
    chk("e_after_depth", depth, 0);

    // depth saturates at 8 and does not go below 0
    min_bit_s = 8'h01; min_bit_a = 8'h00; int_enable = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      cpu_ack = 1;
      cyc();
      cpu_ack = 0;
      cyc(); cyc();
    end
    chk("d_depth8", depth, 8);
    cyc();
    cpu_ack = 1;
    cyc();
    chk("d_call_at8", call_intr, 8'h01);
    cpu_ack = 0;
    cyc();
    chk("d_sat8", depth, 8);
    cyc();
    min_bit_s = 0; min_bit_a = 8'h01;
    for (int i = 0; i < 8; i++) begin
      cpu_reti = 1;
      cyc();
      chk("d_ret_pulse", s_return_intr, 8'h01);
      cpu_reti = 0;
      cyc(); cyc();
    end
    chk("d_depth0", depth, 0);
    chk("d_nospur", spur_reti, 0);
    min_bit_a = 0; cpu_reti = 1;
    cyc();
    chk("d_spur_nopulse", s_return_intr, 0);
    cpu_reti = 0;
    cyc();
    chk("d_spur", spur_reti, 1);
    chk("d_floor0", depth, 0);
    cyc();

`ifdef INTR_MASK_EN
    mask_we = 1; mask_din = 8'hFB;
    cyc();
    mask_we = 0; min_bit_s = 8'h04; min_bit_a = 0; int_enable = 1;
    cyc(); cyc();
    chk("m_masked", intr_req, 0);
    min_bit_s = 8'h02;
    cyc(); cyc();
    chk("m_unmasked", intr_req, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
